// File: rtl/vj_pkg.sv
// Shared definitions for the Viola-Jones scanning datapath: scheduler
// state encoding, the idle level marker, default pyramid geometry and
// the detection window edge.
package vj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_INT = 3'd1,
    ST_SCAN     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } scan_state_t;

  // Level index reported whenever no window is being presented.
  localparam logic [3:0] IMG_INDEX_IDLE = 4'd15;

  // Detection window edge in pixels; a window spans WINDOW_SIZE+1 integral samples.
  localparam int WINDOW_SIZE = 24;

  localparam int PYRAMID_LEVELS_DEFAULT = 9;

  // 320x240 source scaled by roughly 1.2 per level; entry 0 is the full-size image.
  localparam logic [PYRAMID_LEVELS_DEFAULT-1:0][31:0] PYRAMID_WIDTHS = {
    32'd74, 32'd89, 32'd107, 32'd128, 32'd154, 32'd185, 32'd222, 32'd266, 32'd320
  };

  localparam logic [PYRAMID_LEVELS_DEFAULT-1:0][31:0] PYRAMID_HEIGHTS = {
    32'd56, 32'd67, 32'd80, 32'd96, 32'd115, 32'd138, 32'd166, 32'd200, 32'd240
  };

endpackage

// File: rtl/window_walker.sv
// Window position generator: holds the pyramid level, row and column of
// the window currently offered and advances them in raster order, level
// after level. Outside a scan (and after the final window) the level
// register parks at IMG_INDEX_IDLE with both coordinates at zero, so the
// indices can be driven straight out of these registers.
module window_walker #(
  parameter int                        LEVELS        = vj_pkg::PYRAMID_LEVELS_DEFAULT,
  parameter logic [LEVELS-1:0][31:0]   LEVEL_WIDTHS  = vj_pkg::PYRAMID_WIDTHS,
  parameter logic [LEVELS-1:0][31:0]   LEVEL_HEIGHTS = vj_pkg::PYRAMID_HEIGHTS,
  parameter int                        WINDOW_SIZE   = vj_pkg::WINDOW_SIZE,
  parameter int                        COORD_W       = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  output logic [3:0]         img_index,
  output logic [COORD_W-1:0] row_index,
  output logic [COORD_W-1:0] col_index,
  output logic               at_last
);
  import vj_pkg::*;

  localparam logic [3:0] LAST_LEVEL = 4'(LEVELS - 1);

  logic [3:0]         r_level;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;

  logic [LEVELS-1:0]  w_level_hit;
  logic [31:0]        w_cur_w;
  logic [31:0]        w_cur_h;
  logic [COORD_W-1:0] w_col_max;
  logic [COORD_W-1:0] w_row_max;
  logic               w_col_end;
  logic               w_row_end;
  logic               w_level_end;

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level_hit
      assign w_level_hit[gi] = (r_level == 4'(gi));
    end
  endgenerate

  // Select the current level's dimensions; the idle marker selects nothing.
  always_comb begin
    w_cur_w = '0;
    w_cur_h = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (w_level_hit[i]) begin
        w_cur_w = LEVEL_WIDTHS[i];
        w_cur_h = LEVEL_HEIGHTS[i];
      end
    end
  end

  assign w_col_max   = COORD_W'(w_cur_w - 32'(WINDOW_SIZE) - 32'd1);
  assign w_row_max   = COORD_W'(w_cur_h - 32'(WINDOW_SIZE) - 32'd1);
  assign w_col_end   = (r_col == w_col_max);
  assign w_row_end   = (r_row == w_row_max);
  assign w_level_end = (r_level == LAST_LEVEL);

  // Raster advance: column first, then row, then level; the final step parks at idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_level <= IMG_INDEX_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else if (start) begin
      r_level <= 4'd0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (step) begin
      if (w_col_end) begin
        r_col <= '0;
        if (w_row_end) begin
          r_row   <= '0;
          r_level <= w_level_end ? IMG_INDEX_IDLE : r_level + 4'd1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign img_index = r_level;
  assign row_index = r_row;
  assign col_index = r_col;
  assign at_last   = w_level_end && w_row_end && w_col_end;

endmodule

// File: rtl/scan_scheduler.sv
// Frame-level scan controller for the VJ pipeline. After img_rdy it waits
// INT_IMG_WAIT cycles for the integral images to settle, offers every
// window of every pyramid level over valid/ready with at most
// MAX_OUTSTANDING windows in flight, drains outstanding results and then
// pulses frame_done. Optional build macro SCAN_PERF_EN adds the
// stall_cycles port counting SCAN cycles without a handshake.
module scan_scheduler #(
  parameter int                              PYRAMID_LEVELS  = vj_pkg::PYRAMID_LEVELS_DEFAULT,
  parameter logic [PYRAMID_LEVELS-1:0][31:0] LEVEL_WIDTHS    = vj_pkg::PYRAMID_WIDTHS,
  parameter logic [PYRAMID_LEVELS-1:0][31:0] LEVEL_HEIGHTS   = vj_pkg::PYRAMID_HEIGHTS,
  parameter int                              WINDOW_SIZE     = vj_pkg::WINDOW_SIZE,
  parameter int                              INT_IMG_WAIT    = 10,
  parameter int                              MAX_OUTSTANDING = 8,
  parameter int                              COORD_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               img_rdy,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [3:0]         img_index,
  output logic [COORD_W-1:0] row_index,
  output logic [COORD_W-1:0] col_index,
  output logic               last_win,
  input  logic               result_valid,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_drop
`ifdef SCAN_PERF_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);
  import vj_pkg::*;

  localparam int              WAIT_W      = $clog2(INT_IMG_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_TARGET = WAIT_W'(INT_IMG_WAIT);
  localparam int              OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_CAP     = OUT_W'(MAX_OUTSTANDING);

  scan_state_t        r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [OUT_W-1:0]   r_outstanding;
  logic               r_busy;
  logic               r_frame_done;
  logic               r_frame_drop;

  logic               w_win_valid;
  logic               w_handshake;
  logic               w_retire;
  logic               w_start;
  logic               w_at_last;

  assign w_win_valid = (r_state == ST_SCAN) && (r_outstanding < OUT_CAP);
  assign w_handshake = w_win_valid && win_ready;
  // A retire with nothing in flight is spurious and must not wrap the count.
  assign w_retire    = result_valid && (r_outstanding != '0);
  assign w_start     = (r_state == ST_WAIT_INT) && (r_wait_cnt == WAIT_TARGET);

  window_walker #(
    .LEVELS        (PYRAMID_LEVELS),
    .LEVEL_WIDTHS  (LEVEL_WIDTHS),
    .LEVEL_HEIGHTS (LEVEL_HEIGHTS),
    .WINDOW_SIZE   (WINDOW_SIZE),
    .COORD_W       (COORD_W)
  ) u_walker (
    .clock     (clock),
    .reset     (reset),
    .start     (w_start),
    .step      (w_handshake),
    .img_index (img_index),
    .row_index (row_index),
    .col_index (col_index),
    .at_last   (w_at_last)
  );

  // Frame sequencing with registered busy / frame_done / frame_drop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_frame_drop <= img_rdy && (r_state != ST_IDLE);
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (img_rdy) begin
            r_state    <= ST_WAIT_INT;
            r_wait_cnt <= WAIT_W'(1);
            r_busy     <= 1'b1;
          end
        end
        ST_WAIT_INT: begin
          if (r_wait_cnt == WAIT_TARGET) begin
            r_state <= ST_SCAN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_handshake && w_at_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_outstanding == '0) begin
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Windows in flight: issue adds one, retire removes one, both together cancel.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_outstanding <= '0;
    end else if (w_handshake && !w_retire) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_handshake && w_retire) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

`ifdef SCAN_PERF_EN
  logic [31:0] r_stall_cycles;

  // Count SCAN cycles with no handshake; restart on each accepted frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if ((r_state == ST_IDLE) && img_rdy) begin
      r_stall_cycles <= '0;
    end else if ((r_state == ST_SCAN) && !w_handshake && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign win_valid  = w_win_valid;
  assign last_win   = w_win_valid && w_at_last;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_drop = r_frame_drop;

endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler: a frame-level reference model
// (window list, settle timer, in-flight count) is compared against the DUT
// on every cycle, plus literal checks for the directed scenarios.
`timescale 1ns/1ps
module tb_scan_scheduler;

  localparam int LV    = 2;
  localparam int WS    = 24;
  localparam int WAITC = 10;
  localparam int MAXO  = 4;
  localparam int CW    = 16;
  localparam logic [LV-1:0][31:0] TB_W = {32'd27, 32'd26};
  localparam logic [LV-1:0][31:0] TB_H = {32'd26, 32'd25};

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          img_rdy = 1'b0;
  logic          win_ready = 1'b0;
  logic          result_valid = 1'b0;
  logic          win_valid, last_win, busy, frame_done, frame_drop;
  logic [3:0]    img_index;
  logic [CW-1:0] row_index, col_index;
`ifdef SCAN_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clock = ~clock;

  scan_scheduler #(
    .PYRAMID_LEVELS  (LV),
    .LEVEL_WIDTHS    (TB_W),
    .LEVEL_HEIGHTS   (TB_H),
    .WINDOW_SIZE     (WS),
    .INT_IMG_WAIT    (WAITC),
    .MAX_OUTSTANDING (MAXO),
    .COORD_W         (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .img_rdy      (img_rdy),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .img_index    (img_index),
    .row_index    (row_index),
    .col_index    (col_index),
    .last_win     (last_win),
    .result_valid (result_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_drop   (frame_drop)
`ifdef SCAN_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected window list for one frame, in issue order.
  int q_lvl[$];
  int q_row[$];
  int q_col[$];
  int exp_n;

  // Reference model state (describes the current cycle).
  bit          m_on = 0;
  bit          m_busy, m_scan, m_drain, m_done, m_drop;
  int          m_settle, m_k, m_out;
  logic [31:0] m_stall;

  // Advance the model using the inputs held during the cycle just ending.
  always @(posedge clock) begin
    bit v, hs, rv_eff;
    if (reset) begin
      m_on = 1; m_busy = 0; m_scan = 0; m_drain = 0; m_done = 0; m_drop = 0;
      m_settle = 0; m_k = 0; m_out = 0; m_stall = 0;
    end else if (m_on) begin
      v      = m_scan && (m_out < MAXO);
      hs     = v && win_ready;
      rv_eff = result_valid && (m_out > 0);
      m_drop = img_rdy && m_busy;
      if (m_scan && !hs && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_drain) begin
        if (m_out == 0) begin m_drain = 0; m_done = 1; end
      end else if (m_scan) begin
        if (hs) begin
          m_k++;
          if (m_k == exp_n) begin m_scan = 0; m_drain = 1; end
        end
      end else if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin m_scan = 1; m_k = 0; end
      end else if (!m_busy && img_rdy) begin
        m_busy = 1; m_settle = WAITC; m_stall = 0;
      end
      m_out = m_out + (hs ? 1 : 0) - (rv_eff ? 1 : 0);
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clock) begin
    if (m_on) begin
      bit ev;
      int el, er, ec;
      ev = m_scan && (m_out < MAXO);
      el = m_scan ? q_lvl[m_k] : 15;
      er = m_scan ? q_row[m_k] : 0;
      ec = m_scan ? q_col[m_k] : 0;
      chk("win_valid",  32'(win_valid),  32'(ev));
      chk("img_index",  32'(img_index),  el);
      chk("row_index",  32'(row_index),  er);
      chk("col_index",  32'(col_index),  ec);
      chk("last_win",   32'(last_win),   32'(ev && (m_k == exp_n - 1)));
      chk("busy",       32'(busy),       32'(m_busy));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("frame_drop", 32'(frame_drop), 32'(m_drop));
`ifdef SCAN_PERF_EN
      chk("stall_cycles", stall_cycles, m_stall);
`endif
    end
  end

  // Event log used by the directed checks.
  int hs_pos[$];
  int hs_last[$];
  int done_cnt = 0;
  int drop_cnt = 0;
  int cyc = 0;
  bit arm_first = 0;
  int first_valid_cyc = -1;

  always @(negedge clock) begin
    if (win_valid === 1'b1 && win_ready === 1'b1) begin
      hs_pos.push_back(int'(img_index) * 10000 + int'(row_index) * 100 + int'(col_index));
      hs_last.push_back(int'(last_win));
    end
    if (frame_done === 1'b1) done_cnt++;
    if (frame_drop === 1'b1) drop_cnt++;
    if (arm_first && win_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
  end

  // Result echo: each handshake retires three cycles later when enabled.
  bit       echo_en = 0;
  bit [2:0] echo_pipe = '0;

  task automatic tick();
    bit hs_now;
    hs_now = (win_valid === 1'b1) && (win_ready === 1'b1);
    @(posedge clock);
    #1;
    echo_pipe = {echo_pipe[1:0], hs_now};
    cyc++;
    if (echo_en) result_valid = echo_pipe[2];
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk(name, done_cnt - d0, 1);
    repeat (3) tick();
  endtask

  int exp_pos[8] = '{0, 1, 10000, 10001, 10002, 10100, 10101, 10102};

  initial begin
    int base, d0, t_rdy, nlast;
    bit dropped;

    for (int l = 0; l < LV; l++)
      for (int r = 0; r <= int'(TB_H[l]) - WS - 1; r++)
        for (int c = 0; c <= int'(TB_W[l]) - WS - 1; c++) begin
          q_lvl.push_back(l); q_row.push_back(r); q_col.push_back(c);
        end
    exp_n = q_lvl.size();
    chk("model_window_count", exp_n, 8);
    chk("model_last_pos", q_lvl[exp_n-1] * 10000 + q_row[exp_n-1] * 100 + q_col[exp_n-1], 10102);

    // Reset values.
    tick(); tick();
    chk("rst_img_index", 32'(img_index), 15);
    chk("rst_row_col",   32'({row_index, col_index}), 0);
    chk("rst_flags",     32'({win_valid, last_win, busy, frame_done, frame_drop}), 0);
`ifdef SCAN_PERF_EN
    chk("rst_stall", stall_cycles, 0);
`endif
    reset = 0;
    tick();

    // Spurious retires while idle must be ignored.
    result_valid = 1; tick(); tick(); result_valid = 0;
    tick();

    // Full frame with echoed results, settle latency and a dropped img_rdy.
    echo_en = 1; win_ready = 1; base = hs_pos.size(); d0 = drop_cnt;
    arm_first = 1; t_rdy = cyc;
    img_rdy = 1; tick(); img_rdy = 0;
    dropped = 0;
    begin
      int dd;
      dd = done_cnt;
      for (int i = 0; i < 300 && done_cnt == dd; i++) begin
        img_rdy = !dropped && (hs_pos.size() - base >= 3);
        if (img_rdy) dropped = 1;
        tick();
      end
      img_rdy = 0;
      chk("frame1_done_count", done_cnt - dd, 1);
    end
    repeat (3) tick();
    chk("settle_latency", first_valid_cyc - t_rdy, WAITC + 1);
    chk("frame1_handshakes", hs_pos.size() - base, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("frame1_pos%0d", i), hs_pos[base + i], exp_pos[i]);
    nlast = 0;
    for (int i = 0; i < 8; i++) nlast += hs_last[base + i];
    chk("frame1_last_count", nlast, 1);
    chk("frame1_last_on_final", hs_last[base + 7], 1);
    chk("frame1_drop_count", drop_cnt - d0, 1);

    // Outstanding cap with results withheld.
    echo_en = 0; result_valid = 0; win_ready = 1; base = hs_pos.size();
    img_rdy = 1; tick(); img_rdy = 0;
    repeat (30) tick();
    chk("cap_issued", hs_pos.size() - base, 4);
    chk("cap_valid_low", 32'(win_valid), 0);
    result_valid = 1; tick(); result_valid = 0;
    repeat (10) tick();
    chk("cap_one_more", hs_pos.size() - base, 5);
    win_ready = 0; result_valid = 1; repeat (6) tick(); result_valid = 0;
    echo_en = 1; win_ready = 1;
    wait_done("cap_frame_done", 300);

    // Stall accounting: ready held low for the first seven SCAN cycles.
    win_ready = 0;
    img_rdy = 1; tick(); img_rdy = 0;
    for (int i = 0; i < 50 && win_valid !== 1'b1; i++) tick();
    chk("perf_reached_scan", 32'(win_valid), 1);
    repeat (7) tick();
`ifdef SCAN_PERF_EN
    chk("perf_stall7", stall_cycles, 7);
`endif
    win_ready = 1;
    wait_done("perf_frame_done", 300);

    // Reset while the third window is offered.
    base = hs_pos.size();
    img_rdy = 1; tick(); img_rdy = 0;
    for (int i = 0; i < 100 && hs_pos.size() - base < 2; i++) tick();
    chk("midrst_two_issued", hs_pos.size() - base, 2);
    d0 = done_cnt;
    reset = 1; tick(); reset = 0;
    chk("midrst_img_index", 32'(img_index), 15);
    chk("midrst_win_valid", 32'(win_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    repeat (30) tick();
    chk("midrst_no_done", done_cnt - d0, 0);

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      win_ready = ($urandom_range(0, 9) < 7);
      img_rdy   = ($urandom_range(0, 29) == 0);
      tick();
    end
    img_rdy = 0; win_ready = 1;
    for (int i = 0; i < 400 && busy !== 1'b0; i++) tick();
    chk("final_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
